// File: rtl/context_switch_handler.sv
// context_switch_handler
// Saves the interrupted process PC, round-robin selects the next runnable
// process from a per-process table and issues a one-cycle PC-load strobe.
// With no runnable process the OS entry point is loaded instead.
module context_switch_handler #(
  parameter int unsigned     NUM_PROC = 8,
  parameter int unsigned     PID_W    = 3,
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] OS_ENTRY = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             troca_contexto,
  input  logic [PC_W-1:0]  pc_processo_trocado,
  input  logic             fim_processo,
  input  logic             cria_processo,
  input  logic [PID_W-1:0] cria_pid,
  input  logic [PC_W-1:0]  cria_pc,
  output logic [PID_W-1:0] processo_atual,
  output logic [PC_W-1:0]  pc_novo,
  output logic             carrega_pc,
  output logic             ocupado,
  output logic             sem_processo
);

  typedef enum logic [1:0] {
    IDLE,
    SAVE,
    SEARCH,
    LOAD
  } state_t;

  localparam logic [PID_W:0] CNT_LAST = (PID_W+1)'(NUM_PROC - 1);

  state_t           state;
  state_t           state_next;

  logic [PC_W-1:0]  table_pc [NUM_PROC];
  logic [NUM_PROC-1:0] valid;

  logic [PID_W-1:0] ptr;
  logic [PID_W:0]   cnt;
  logic             pending_fim;
  logic             troca_q;
  logic             fim_q;

  logic             troca_evt;
  logic             fim_evt;

  // control strobes from the next-state logic
  logic             start_search;
  logic             invalidate;
  logic             save;
  logic             step;
  logic             enter_load;
  logic             hit;

  // rising-edge events of the two request levels
  always_comb begin
    troca_evt = troca_contexto & ~troca_q;
    fim_evt   = fim_processo & ~fim_q;
  end

  // busy whenever a switch is in progress
  always_comb begin
    ocupado = (state != IDLE);
  end

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // next-state and control decode; fim takes priority over a troca event
  always_comb begin
    state_next   = state;
    start_search = 1'b0;
    invalidate   = 1'b0;
    save         = 1'b0;
    step         = 1'b0;
    enter_load   = 1'b0;
    hit          = 1'b0;
    case (state)
      IDLE: begin
        if (fim_evt || pending_fim) begin
          invalidate   = 1'b1;
          start_search = 1'b1;
          state_next   = SEARCH;
        end else if (troca_evt) begin
          state_next = SAVE;
        end
      end
      SAVE: begin
        save         = 1'b1;
        start_search = 1'b1;
        state_next   = SEARCH;
      end
      SEARCH: begin
        if (valid[ptr]) begin
          hit        = 1'b1;
          enter_load = 1'b1;
          state_next = LOAD;
        end else if (cnt == CNT_LAST) begin
          enter_load = 1'b1;
          state_next = LOAD;
        end else begin
          step = 1'b1;
        end
      end
      LOAD: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // edge-detect registers and deferred fim request
  always_ff @(posedge clock) begin
    if (reset) begin
      troca_q     <= 1'b0;
      fim_q       <= 1'b0;
      pending_fim <= 1'b0;
    end else begin
      troca_q <= troca_contexto;
      fim_q   <= fim_processo;
      if (invalidate)
        pending_fim <= 1'b0;
      if (fim_evt && (state != IDLE))
        pending_fim <= 1'b1;
    end
  end

  // search pointer and examined-entry count
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
    end else if (start_search) begin
      ptr <= processo_atual + PID_W'(1);
      cnt <= '0;
    end else if (step) begin
      ptr <= ptr + PID_W'(1);
      cnt <= cnt + (PID_W+1)'(1);
    end
  end

  // process table; a create is written last so it wins over save/invalidate
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PROC; i++)
        table_pc[i] <= '0;
      valid <= '0;
    end else begin
      if (save)
        table_pc[processo_atual] <= pc_processo_trocado;
      if (invalidate)
        valid[processo_atual] <= 1'b0;
      if (cria_processo) begin
        table_pc[cria_pid] <= cria_pc;
        valid[cria_pid]    <= 1'b1;
      end
    end
  end

  // output registers, updated on entry to LOAD so they are valid with the strobe
  always_ff @(posedge clock) begin
    if (reset) begin
      processo_atual <= '0;
      pc_novo        <= OS_ENTRY;
      carrega_pc     <= 1'b0;
      sem_processo   <= 1'b1;
    end else begin
      carrega_pc <= enter_load;
      if (enter_load) begin
        if (hit) begin
          pc_novo        <= table_pc[ptr];
          processo_atual <= ptr;
          sem_processo   <= 1'b0;
        end else begin
          pc_novo      <= OS_ENTRY;
          sem_processo <= 1'b1;
        end
      end
    end
  end

endmodule
